// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with input FIFO, optional parity and 1/2 stop bits.
module uart_tx_param #(
   parameter int CLKS_PER_BIT = 87,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        i_Clock,
   input  logic                        i_Rst_L,
   input  logic                        i_Tx_DV,
   input  logic [DATA_BITS-1:0]        i_Tx_Byte,
   output logic                        o_Tx_Ready,
   output logic                        o_Tx_Overflow,
   output logic                        o_Tx_Serial,
   output logic                        o_Tx_Active,
   output logic                        o_Tx_Done,
   output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP} state_t;

   state_t               state, state_n;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          count;
   logic [CW-1:0]        clk_cnt, clk_cnt_n;
   logic [BW-1:0]        bit_idx, bit_idx_n;
   logic [DATA_BITS-1:0] shift, shift_n;
   logic                 par, par_n, serial_n, active_n, done_n, pop, wr, bit_end;

   assign o_Tx_Ready   = count != FULL;
   assign o_Fifo_Count = count;
   assign wr           = i_Tx_DV && o_Tx_Ready;
   assign bit_end      = clk_cnt == CNT_LAST;

   always_comb begin
      state_n   = state;
      clk_cnt_n = bit_end ? '0 : clk_cnt + 1'b1;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      par_n     = par;
      serial_n  = o_Tx_Serial;
      active_n  = o_Tx_Active;
      done_n    = 1'b0;
      pop       = 1'b0;
      case (state)
         IDLE, CLEANUP: begin
            serial_n  = 1'b1;
            active_n  = 1'b0;
            clk_cnt_n = '0;
            bit_idx_n = '0;
            state_n   = IDLE;
            if (count != '0) begin
               pop      = 1'b1;
               shift_n  = mem[rd_ptr];
               par_n    = (PARITY_MODE == 2) ^ (^mem[rd_ptr]);
               state_n  = START;
               serial_n = 1'b0;
               active_n = 1'b1;
            end
         end
         START: if (bit_end) begin
            state_n  = DATA;
            serial_n = shift[0];
            shift_n  = shift >> 1;
         end
         DATA: if (bit_end) begin
            if (bit_idx == BIT_LAST) begin
               bit_idx_n = '0;
               state_n   = PARITY_MODE != 0 ? PARITY : STOP;
               serial_n  = PARITY_MODE != 0 ? par : 1'b1;
            end else begin
               bit_idx_n = bit_idx + 1'b1;
               serial_n  = shift[0];
               shift_n   = shift >> 1;
            end
         end
         PARITY: if (bit_end) begin
            state_n  = STOP;
            serial_n = 1'b1;
         end
         STOP: if (bit_end) begin
            if (bit_idx == STOP_LAST) begin
               state_n  = CLEANUP;
               active_n = 1'b0;
               done_n   = 1'b1;
            end else begin
               bit_idx_n = bit_idx + 1'b1;
            end
         end
         default: begin
            state_n  = IDLE;
            serial_n = 1'b1;
            active_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_L) begin
         state         <= IDLE;
         clk_cnt       <= '0;
         bit_idx       <= '0;
         shift         <= '0;
         par           <= 1'b0;
         o_Tx_Serial   <= 1'b1;
         o_Tx_Active   <= 1'b0;
         o_Tx_Done     <= 1'b0;
         o_Tx_Overflow <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
      end else begin
         state         <= state_n;
         clk_cnt       <= clk_cnt_n;
         bit_idx       <= bit_idx_n;
         shift         <= shift_n;
         par           <= par_n;
         o_Tx_Serial   <= serial_n;
         o_Tx_Active   <= active_n;
         o_Tx_Done     <= done_n;
         o_Tx_Overflow <= i_Tx_DV && !o_Tx_Ready;
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW + 1)'(wr) - (AW + 1)'(pop);
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge i_Clock) if (wr) mem[wr_ptr] <= i_Tx_Byte;
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: four transmitter configurations checked every cycle against a frame-schedule model.
module tb_uart_tx_param;
   localparam int CPB [4] = '{4, 4, 4, 3};
   localparam int DB  [4] = '{8, 8, 8, 5};
   localparam int PM  [4] = '{0, 1, 2, 0};
   localparam int SB  [4] = '{1, 2, 1, 1};
   localparam int FD  [4] = '{4, 4, 4, 2};

   logic            clk = 1'b0;
   logic            rst_l = 1'b0;
   logic [3:0]      dv = '0;
   logic [3:0][8:0] din = '0;
   logic [3:0]      ready, ovf, ser, act, done;
   logic [2:0]      c0, c1, c2;
   logic [1:0]      c3;

   int         total = 0, bad = 0, cyc = 0;
   int         fs [4][64];
   int         fw [4][64];
   logic [8:0] fb [4][64];
   int         nf [4], first [4], last_s [4];
   logic       eovf [4];

   always #5 clk = ~clk;

   uart_tx_param #(.CLKS_PER_BIT(CPB[0]), .DATA_BITS(DB[0]), .PARITY_MODE(PM[0]), .STOP_BITS(SB[0]), .FIFO_DEPTH(FD[0])) u0 (
      .i_Clock(clk), .i_Rst_L(rst_l), .i_Tx_DV(dv[0]), .i_Tx_Byte(din[0][7:0]), .o_Tx_Ready(ready[0]),
      .o_Tx_Overflow(ovf[0]), .o_Tx_Serial(ser[0]), .o_Tx_Active(act[0]), .o_Tx_Done(done[0]), .o_Fifo_Count(c0));
   uart_tx_param #(.CLKS_PER_BIT(CPB[1]), .DATA_BITS(DB[1]), .PARITY_MODE(PM[1]), .STOP_BITS(SB[1]), .FIFO_DEPTH(FD[1])) u1 (
      .i_Clock(clk), .i_Rst_L(rst_l), .i_Tx_DV(dv[1]), .i_Tx_Byte(din[1][7:0]), .o_Tx_Ready(ready[1]),
      .o_Tx_Overflow(ovf[1]), .o_Tx_Serial(ser[1]), .o_Tx_Active(act[1]), .o_Tx_Done(done[1]), .o_Fifo_Count(c1));
   uart_tx_param #(.CLKS_PER_BIT(CPB[2]), .DATA_BITS(DB[2]), .PARITY_MODE(PM[2]), .STOP_BITS(SB[2]), .FIFO_DEPTH(FD[2])) u2 (
      .i_Clock(clk), .i_Rst_L(rst_l), .i_Tx_DV(dv[2]), .i_Tx_Byte(din[2][7:0]), .o_Tx_Ready(ready[2]),
      .o_Tx_Overflow(ovf[2]), .o_Tx_Serial(ser[2]), .o_Tx_Active(act[2]), .o_Tx_Done(done[2]), .o_Fifo_Count(c2));
   uart_tx_param #(.CLKS_PER_BIT(CPB[3]), .DATA_BITS(DB[3]), .PARITY_MODE(PM[3]), .STOP_BITS(SB[3]), .FIFO_DEPTH(FD[3])) u3 (
      .i_Clock(clk), .i_Rst_L(rst_l), .i_Tx_DV(dv[3]), .i_Tx_Byte(din[3][4:0]), .o_Tx_Ready(ready[3]),
      .o_Tx_Overflow(ovf[3]), .o_Tx_Serial(ser[3]), .o_Tx_Active(act[3]), .o_Tx_Done(done[3]), .o_Fifo_Count(c3));

   function automatic logic [3:0] cnt(int i);
      return i == 0 ? {1'b0, c0} : i == 1 ? {1'b0, c1} : i == 2 ? {1'b0, c2} : {2'b00, c3};
   endfunction

   function automatic int flen(int i);
      return CPB[i] * (1 + DB[i] + (PM[i] != 0 ? 1 : 0) + SB[i]);
   endfunction

   function automatic int base(int i);
      return nf[i] - 8 > first[i] ? nf[i] - 8 : first[i];
   endfunction

   // Bytes written by edge t and not yet started by edge t.
   function automatic int qcount(int i, int t);
      int n = 0;
      for (int k = base(i); k < nf[i]; k++)
         if (fw[i][k % 64] <= t && fs[i][k % 64] > t) n++;
      return n;
   endfunction

   // Bit j of a frame: start, payload LSB first, optional parity, then stop bits.
   function automatic logic ebit(int i, logic [8:0] b, int j);
      logic [8:0] m = b & ((9'h1 << DB[i]) - 9'h1);
      if (j == 0) return 1'b0;
      if (j <= DB[i]) return m[j-1];
      if (j == DB[i] + 1 && PM[i] != 0) return (^m) ^ (PM[i] == 2);
      return 1'b1;
   endfunction

   task automatic chk(string tag, int i, logic [3:0] got, logic [3:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s[%0d] cyc=%0d observed=%0h expected=%0h", tag, i, cyc, got, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 4; i++) begin
         logic es, ea, ed;
         int n;
         es = 1'b1;
         ea = 1'b0;
         ed = 1'b0;
         for (int k = base(i); k < nf[i]; k++) begin
            int d = cyc - fs[i][k % 64];
            if (d >= 0 && d < flen(i)) begin
               ea = 1'b1;
               es = ebit(i, fb[i][k % 64], d / CPB[i]);
            end
            if (d == flen(i)) ed = 1'b1;
         end
         n = qcount(i, cyc);
         chk("serial", i, {3'b0, ser[i]}, {3'b0, es});
         chk("active", i, {3'b0, act[i]}, {3'b0, ea});
         chk("done", i, {3'b0, done[i]}, {3'b0, ed});
         chk("overflow", i, {3'b0, ovf[i]}, {3'b0, eovf[i]});
         chk("ready", i, {3'b0, ready[i]}, {3'b0, n != FD[i]});
         chk("count", i, cnt(i), n[3:0]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (!rst_l) begin
            first[i] = nf[i];
            last_s[i] = -100000;
            eovf[i] = 1'b0;
         end else begin
            eovf[i] = dv[i] && qcount(i, cyc - 1) == FD[i];
            if (dv[i] && !eovf[i]) begin
               int s = cyc + 1;
               if (last_s[i] + flen(i) + 1 > s) s = last_s[i] + flen(i) + 1;
               fs[i][nf[i] % 64] = s;
               fw[i][nf[i] % 64] = cyc;
               fb[i][nf[i] % 64] = din[i];
               nf[i]++;
               last_s[i] = s;
            end
         end
      end
      #1;
      check_all();
   endtask

   task automatic run(int n);
      repeat (n) tick();
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         nf[i] = 0;
         first[i] = 0;
         last_s[i] = -100000;
         eovf[i] = 1'b0;
      end
      run(3);
      rst_l = 1'b1;
      run(2);
      dv = 4'b1111;
      din[0] = 9'h0A5;
      din[1] = 9'h007;
      din[2] = 9'h007;
      din[3] = 9'h1F3;
      tick();
      dv = '0;
      run(60);
      for (int k = 0; k < 6; k++) begin
         dv = '0;
         dv[0] = 1'b1;
         din[0] = 9'($urandom);
         if (k < 4) begin
            dv[3] = 1'b1;
            din[3] = 9'($urandom);
         end
         tick();
      end
      // Keep writing into a full FIFO across the first CLEANUP edge.
      dv = '0;
      for (int k = 0; k < 60; k++) begin
         dv[0] = 1'b1;
         din[0] = 9'($urandom);
         tick();
      end
      dv = '0;
      run(260);
      dv = 4'b1111;
      din = {9'h13C, 9'h0FF, 9'h081, 9'h05A};
      tick();
      dv = '0;
      run(15);
      rst_l = 1'b0;
      run(3);
      rst_l = 1'b1;
      run(10);
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < 4; i++) begin
            dv[i] = ($urandom % 16) < 3;
            din[i] = 9'($urandom);
         end
         tick();
      end
      dv = '0;
      run(300);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
